// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin channel arbiter.
// Provides the state encoding, the requester index type and the rotating pick function.
package mux4_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    typedef logic [1:0] req_idx_t;

    // Scan runs from the farthest slot back toward ptr so the nearest hit overwrites earlier ones.
    function automatic req_idx_t rr_pick(input logic [N_REQ-1:0] req, input req_idx_t ptr);
        req_idx_t idx;
        rr_pick = ptr;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            idx = ptr + req_idx_t'(i - 1);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input req_idx_t idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Combinational 4:1 data select for the shared output channel.
module mux4
#(
    parameter int unsigned W = 1
)
(
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a 4:1 output mux: registered one-hot grant and select,
// owner held for its transfer and rotated after MAX_HOLD cycles when others wait.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned W        = 1,
    parameter int unsigned MAX_HOLD = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic         busy,
    output logic [W-1:0] out
);

    localparam int unsigned    CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_ONE = CW'(1);

    arb_state_e       state, state_n;
    req_idx_t         ptr, ptr_n;
    req_idx_t         owner, owner_n;
    logic [CW-1:0]    hold_cnt, hold_n;
    logic [3:0]       gnt_n;
    logic [3:0]       others;
    req_idx_t         next_ptr;
    logic             rotate;
    logic [W-1:0]     mux_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
        end
    end

    assign others   = req & ~onehot(owner);
    assign next_ptr = owner + 2'd1;
    // Release and preemption both move ptr past the owner; release wins, but the result is identical.
    assign rotate   = !req[owner] || ((hold_cnt == HOLD_MAX) && (|others));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    owner_n = rr_pick(req, ptr);
                    gnt_n   = onehot(owner_n);
                    hold_n  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (rotate) begin
                    ptr_n = next_ptr;
                    if (|others) begin
                        owner_n = rr_pick(others, next_ptr);
                        gnt_n   = onehot(owner_n);
                        hold_n  = HOLD_ONE;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        hold_n  = '0;
                    end
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    assign sel  = owner;
    assign busy = (state == GRANT);

    mux4 #(.W(W)) u_mux4 (
        .sel (owner),
        .d0  (in1),
        .d1  (in2),
        .d2  (in3),
        .d3  (in4),
        .y   (mux_y)
    );

    assign out = busy ? mux_y : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter (W=1, MAX_HOLD=2).
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       in1, in2, in3, in4;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       out;

    int unsigned n_checks;
    int unsigned n_pass;

    mux4_rr_arbiter #(.W(1), .MAX_HOLD(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .in4  (in4),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed mid-cycle, well away from any rising edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},  gnt,  32'h0);
        check({tag, "_busy"}, busy, 32'h0);
        check({tag, "_out"},  out,  32'h0);
    endtask

    int unsigned exp_owner [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        req = 4'b1111;
        {in1, in2, in3, in4} = 4'b0111;

        // Reset holds everything idle despite all requests asserted.
        #3;
        check_idle("rst");
        check("rst_sel", sel, 32'h0);
        tick();
        check_idle("rst_edge");

        // First grant after release of reset.
        rst = 1'b0;
        req = 4'b0010;
        tick();
        check("first_gnt",  gnt,  32'h2);
        check("first_sel",  sel,  32'h1);
        check("first_busy", busy, 32'h1);
        check("first_out",  out,  32'h1);

        // Release tail: grant survives the cycle req is low, then clears; sel keeps owner.
        req = 4'b0000;
        check("tail_gnt", gnt, 32'h2);
        tick();
        check_idle("rel");
        check("rel_sel", sel, 32'h1);
        tick();
        check("idle_stay_busy", busy, 32'h0);

        // Sole requester is never preempted.
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("solo_gnt", gnt, 32'h4);
        end
        req = 4'b0000;
        check("solo_tail", gnt, 32'h4);
        tick();
        check_idle("solo_rel");

        // Full contention from reset: each owner gets exactly MAX_HOLD cycles.
        pulse_reset();
        check("rst2_gnt", gnt, 32'h0);
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("cont_sel",  sel,  exp_owner[i]);
            check("cont_gnt",  gnt,  32'h1 << exp_owner[i]);
            check("cont_out",  out,  (exp_owner[i] == 0) ? 32'h0 : 32'h1);
            check("cont_busy", busy, 32'h1);
        end

        // Release handover with no idle bubble.
        req = 4'b0000;
        pulse_reset();
        req = 4'b0011;
        tick();
        check("ho_gnt0", gnt, 32'h1);
        req = 4'b0010;
        check("ho_tail", gnt, 32'h1);
        tick();
        check("ho_gnt1",  gnt,  32'h2);
        check("ho_busy",  busy, 32'h1);
        check("ho_sel",   sel,  32'h1);

        // Async reset mid-grant takes effect before the next edge.
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        tick();
        check("mid_gnt", gnt, 32'h4);
        #2 rst = 1'b1;
        #1;
        check_idle("async");
        check("async_sel", sel, 32'h0);
        #1 rst = 1'b0;
        req = 4'b1100;
        tick();
        check("post_gnt", gnt, 32'h4);
        check("post_sel", sel, 32'h2);
        check("post_out", out, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 multiplexed output channel among four requesters. It owns the mux select: it decides which requester's data drives the shared output, holds that choice for the duration of the owner's transfer, and force-rotates after a bounded number of cycles when other requesters are waiting. It sits between the requesting sources and the 4:1 select mux, replacing hand-driven select lines with a fair, registered scheduler.

## Interface
- `W`, default 1: data width per requester and of the output.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one owner while others wait; legal range ≥1.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req` input, 4 bits: `req[i]` is requester i asking for the channel; held high for the whole transfer.
- `in1`..`in4` input, W bits each: requester data (requester 0..3).
- `gnt` output, 4 bits: registered one-hot grant; all-zero when idle.
- `sel` output, 2 bits: registered owner index, wired to the mux select as {s2,s1}.
- `busy` output, 1 bit: channel owned (state GRANT).
- `out` output, W bits: selected data when busy, else all-zero.

## Operation
- State machine: IDLE, GRANT. Internal: `ptr` (2 bits, highest-priority index), `owner` (2 bits), `hold_cnt` (clog2(MAX_HOLD+1) bits).
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, out=0, ptr=0, hold_cnt=0.
- Pick function: first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: req=0 → stay. req≠0 → GRANT, owner=pick, gnt=onehot(owner), sel=owner, hold_cnt=1.
- GRANT, owner k, evaluated each edge:
  - req[k]=0 (release): ptr=k+1 mod 4. Other req pending → grant pick directly (no idle bubble), hold_cnt=1. Else → IDLE, gnt=0; sel keeps k.
  - req[k]=1, hold_cnt=MAX_HOLD, any other req pending (preempt): ptr=k+1 mod 4, grant pick (never k), hold_cnt=1.
  - Otherwise: keep grant; hold_cnt increments, saturating at MAX_HOLD.
- Sole requester is never preempted; it holds indefinitely.
- `out`: combinational, the `in` selected by `sel` when busy=1, else 0.
- Requests not yet granted are only ever sampled, never latched; a requester dropping req before grant loses its slot silently.

## Timing
- Grant latency: req rising in cycle n → gnt/sel/busy valid after the edge ending cycle n (1 cycle).
- Release tail: the owner's gnt stays high during the cycle in which its req is first low; it clears or moves at the following edge.
- Under contention an owner holds gnt for exactly MAX_HOLD cycles, then the next requester in rotation gets it at the next edge; handover is back-to-back, one gnt bit active at all times, never two.
- Simultaneous release and preemption condition: release takes precedence (same resulting ptr).
- Reset asserted mid-grant: all outputs reach reset values immediately (asynchronous), independent of clk; first grant after reset deassertion follows normal 1-cycle latency with ptr=0.

## Structure
- Shared package: `N_REQ=4` constant, `arb_state_e` {IDLE, GRANT}, 2-bit `req_idx_t` type, and the rotate-pick function.
- One sub-module: `mux4`, the combinational 4:1 W-bit data select driven by `sel`; arbiter FSM, pointer and counter stay in the top.

## Test plan
- Reset: rst=1 with req=4'b1111 → gnt=0000, sel=00, busy=0, out=0; release rst, req=0010 → gnt=0010, sel=01 one edge later.
- Single requester: req=0100 for 10 cycles, MAX_HOLD=4 → gnt=0100 all 10 cycles, no preemption; drop req → gnt=0100 for one more cycle, then 0000, busy=0.
- Full contention, MAX_HOLD=2, req=1111 from reset → owners 0,0,1,1,2,2,3,3,0,0, with exactly one gnt bit high every cycle.
- Release handover: req=0011, owner 0 drops req after 1 cycle → gnt moves 0001→0010 with no idle cycle; ptr skips to 1.
- Data path: in1..in4 = 0,1,1,1 (W=1), grants rotating 0..3 → out follows 0,1,1,1 aligned with sel; out=0 while idle.
- Async reset mid-grant: owner 2 holding, rst pulsed between edges → gnt=0, sel=00 before the next edge; after release, req=1100 → grant goes to 2 (scan from ptr=0).
